pwm_carrier_event_gen: RTL and testbench

- Generates the triangular PWM carrier and the peak/valley event pulses that drive the timing manager's event_qualifier input.
- The selected carrier events form the qualified-event stream, which the timing manager counts against its user ratio to schedule sensor triggers and the scheduler ISR.
- Sits directly upstream of the timing manager, between the AXI register file (configuration) and the PWM comparators and timing manager (consumers).

---
 rtl/pwm_carrier_event_gen.sv | 145 ++++++++++++++
 tb/tb_pwm_carrier_event_gen.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pwm_carrier_event_gen.sv
// Triangular PWM carrier with prescaler, shadowed peak/divider and peak/valley event pulses.
// Selected events drive the timing manager's event_qualifier input and a wrapping event counter.
module pwm_carrier_event_gen #(
    parameter int CW = 16,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic [CW-1:0] carrier_max,
    input  logic [DW-1:0] carrier_div,
    input  logic [1:0]    event_sel,
    output logic [CW-1:0] carrier,
    output logic          carrier_dir,
    output logic          carrier_high,
    output logic          carrier_low,
    output logic          event_qualifier,
    output logic [15:0]   event_count
);

    typedef enum logic {
        ST_DOWN = 1'b0,
        ST_UP   = 1'b1
    } state_t;

    localparam logic [CW-1:0] CARRIER_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CARRIER_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] MAX_FLOOR    = {{(CW-2){1'b0}}, 2'b10};
    localparam logic [DW-1:0] DIV_ZERO     = {DW{1'b0}};
    localparam logic [DW-1:0] DIV_ONE      = {{(DW-1){1'b0}}, 1'b1};

    state_t        state_q, state_d;
    logic [CW-1:0] carrier_q, carrier_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [CW-1:0] max_s_q, max_s_d;
    logic [DW-1:0] div_s_q, div_s_d;
    logic          high_q, high_d;
    logic          low_q, low_d;
    logic          qual_q, qual_d;
    logic [15:0]   count_q, count_d;

    logic          tick_s;
    logic [CW-1:0] max_eff_s;
    logic [CW-1:0] max_m1_s;

    // Next-state logic: prescaler, triangle FSM, shadow reload and event generation.
    always_comb begin
        tick_s    = enable && (div_cnt_q == div_s_q);
        // A peak below 2 would let peak and valley collide, so it is floored here.
        max_eff_s = (max_s_q < MAX_FLOOR) ? MAX_FLOOR : max_s_q;
        max_m1_s  = max_eff_s - CARRIER_ONE;

        state_d   = state_q;
        carrier_d = carrier_q;
        div_cnt_d = div_cnt_q;
        max_s_d   = max_s_q;
        div_s_d   = div_s_q;
        high_d    = 1'b0;
        low_d     = 1'b0;

        if (!enable) begin
            state_d   = ST_UP;
            carrier_d = CARRIER_ZERO;
            div_cnt_d = DIV_ZERO;
            max_s_d   = carrier_max;
            div_s_d   = carrier_div;
        end else begin
            div_cnt_d = tick_s ? DIV_ZERO : (div_cnt_q + DIV_ONE);
            if (tick_s) begin
                case (state_q)
                    ST_UP: begin
                        if (carrier_q < max_m1_s) begin
                            carrier_d = carrier_q + CARRIER_ONE;
                        end else begin
                            carrier_d = max_eff_s;
                            state_d   = ST_DOWN;
                            high_d    = 1'b1;
                        end
                    end
                    ST_DOWN: begin
                        if (carrier_q > CARRIER_ONE) begin
                            carrier_d = carrier_q - CARRIER_ONE;
                        end else begin
                            // Valley: the only point where new max/div take effect.
                            carrier_d = CARRIER_ZERO;
                            state_d   = ST_UP;
                            low_d     = 1'b1;
                            max_s_d   = carrier_max;
                            div_s_d   = carrier_div;
                        end
                    end
                    default: begin
                        carrier_d = CARRIER_ZERO;
                        state_d   = ST_UP;
                    end
                endcase
            end else begin
                carrier_d = carrier_q;
            end
        end

        qual_d = (high_d && event_sel[0]) || (low_d && event_sel[1]);

        if (!enable) begin
            count_d = 16'h0000;
        end else if (qual_d) begin
            count_d = count_q + 16'h0001;
        end else begin
            count_d = count_q;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_UP;
            carrier_q <= CARRIER_ZERO;
            div_cnt_q <= DIV_ZERO;
            max_s_q   <= CARRIER_ZERO;
            div_s_q   <= DIV_ZERO;
            high_q    <= 1'b0;
            low_q     <= 1'b0;
            qual_q    <= 1'b0;
            count_q   <= 16'h0000;
        end else begin
            state_q   <= state_d;
            carrier_q <= carrier_d;
            div_cnt_q <= div_cnt_d;
            max_s_q   <= max_s_d;
            div_s_q   <= div_s_d;
            high_q    <= high_d;
            low_q     <= low_d;
            qual_q    <= qual_d;
            count_q   <= count_d;
        end
    end

    assign carrier         = carrier_q;
    assign carrier_dir     = (state_q == ST_UP);
    assign carrier_high    = high_q;
    assign carrier_low     = low_q;
    assign event_qualifier = qual_q;
    assign event_count     = count_q;

endmodule

// File: tb/tb_pwm_carrier_event_gen.sv
// Directed self-checking bench for pwm_carrier_event_gen.
// Expected carrier values come from a closed-form triangle formula evaluated per step.
module tb_pwm_carrier_event_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] carrier_max = 16'd0;
    logic [7:0]  carrier_div = 8'd0;
    logic [1:0]  event_sel = 2'b00;
    logic [15:0] carrier;
    logic        carrier_dir;
    logic        carrier_high;
    logic        carrier_low;
    logic        event_qualifier;
    logic [15:0] event_count;

    int n_chk = 0;
    int n_err = 0;
    int ecnt  = 0;

    pwm_carrier_event_gen #(.CW(16), .DW(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .carrier_max     (carrier_max),
        .carrier_div     (carrier_div),
        .event_sel       (event_sel),
        .carrier         (carrier),
        .carrier_dir     (carrier_dir),
        .carrier_high    (carrier_high),
        .carrier_low     (carrier_low),
        .event_qualifier (event_qualifier),
        .event_count     (event_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step k after the segment start: each value lasts d+1 cycles, period 2*m values.
    task automatic chk_point(input int k, input int m, input int d, input bit v0, input logic [1:0] sel);
        int idx, ph, p, c;
        bit h, l, dir, q;
        idx = k / (d + 1);
        ph  = k % (d + 1);
        p   = idx % (2 * m);
        c   = (p <= m) ? p : (2 * m - p);
        h   = (ph == 0) && (p == m);
        l   = (ph == 0) && (p == 0) && ((idx > 0) || v0);
        dir = (p < m);
        q   = (h && sel[0]) || (l && sel[1]);
        if (q) ecnt = (ecnt + 1) & 32'h0000_FFFF;
        check_eq("carrier", 32'(carrier), 32'(c));
        check_eq("dir",     32'(carrier_dir), 32'(dir));
        check_eq("high",    32'(carrier_high), 32'(h));
        check_eq("low",     32'(carrier_low), 32'(l));
        check_eq("qual",    32'(event_qualifier), 32'(q));
        check_eq("count",   32'(event_count), 32'(ecnt));
    endtask

    task automatic run_seg(input int k0, input int k1, input int m, input int d, input bit v0, input logic [1:0] sel);
        for (int k = k0; k <= k1; k++) begin
            step();
            chk_point(k, m, d, v0, sel);
        end
    endtask

    task automatic start(input logic [15:0] m, input logic [7:0] d, input logic [1:0] sel);
        enable      = 1'b0;
        carrier_max = m;
        carrier_div = d;
        event_sel   = sel;
        step();
        step();
        enable = 1'b1;
        ecnt   = 0;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_carrier"}, 32'(carrier), 32'd0);
        check_eq({tag, "_dir"},     32'(carrier_dir), 32'd1);
        check_eq({tag, "_high"},    32'(carrier_high), 32'd0);
        check_eq({tag, "_low"},     32'(carrier_low), 32'd0);
        check_eq({tag, "_qual"},    32'(event_qualifier), 32'd0);
        check_eq({tag, "_count"},   32'(event_count), 32'd0);
    endtask

    initial begin
        #12;
        check_idle("reset");
        rst_n = 1'b1;

        // max=4 div=0, peaks only: peaks at steps 4, 12, 20.
        start(16'd4, 8'd0, 2'b01);
        chk_point(0, 4, 0, 1'b0, 2'b01);
        run_seg(1, 24, 4, 0, 1'b0, 2'b01);
        check_eq("three_peaks", 32'(event_count), 32'd3);

        // max=4 div=2, both events: period 24, event every 12 cycles.
        start(16'd4, 8'd2, 2'b11);
        chk_point(0, 4, 2, 1'b0, 2'b11);
        run_seg(1, 48, 4, 2, 1'b0, 2'b11);

        // Raise max mid-period: old peak 4 holds until the valley, then peak 6.
        start(16'd4, 8'd0, 2'b01);
        chk_point(0, 4, 0, 1'b0, 2'b01);
        run_seg(1, 2, 4, 0, 1'b0, 2'b01);
        carrier_max = 16'd6;
        run_seg(3, 7, 4, 0, 1'b0, 2'b01);
        run_seg(0, 15, 6, 0, 1'b1, 2'b01);

        // max below 2 behaves as 2.
        start(16'd1, 8'd0, 2'b11);
        chk_point(0, 2, 0, 1'b0, 2'b11);
        run_seg(1, 8, 2, 0, 1'b0, 2'b11);
        start(16'd0, 8'd0, 2'b11);
        chk_point(0, 2, 0, 1'b0, 2'b11);
        run_seg(1, 8, 2, 0, 1'b0, 2'b11);

        // Disable while counting down at 3, then restart from 0 without a valley pulse.
        start(16'd4, 8'd0, 2'b01);
        chk_point(0, 4, 0, 1'b0, 2'b01);
        run_seg(1, 5, 4, 0, 1'b0, 2'b01);
        enable = 1'b0;
        step();
        check_idle("disable");
        enable = 1'b1;
        ecnt   = 0;
        chk_point(0, 4, 0, 1'b0, 2'b01);
        run_seg(1, 9, 4, 0, 1'b0, 2'b01);

        // Counter wrap from 0xFFFE after two events.
        start(16'd2, 8'd0, 2'b11);
        chk_point(0, 2, 0, 1'b0, 2'b11);
        force dut.count_q = 16'hFFFE;
        #1;
        release dut.count_q;
        ecnt = 32'h0000_FFFE;
        check_eq("preload", 32'(event_count), 32'h0000_FFFE);
        run_seg(1, 4, 2, 0, 1'b0, 2'b11);
        check_eq("wrap", 32'(event_count), 32'h0000_0000);

        // Asynchronous reset mid-count, observed before the next clock edge.
        start(16'd4, 8'd0, 2'b11);
        chk_point(0, 4, 0, 1'b0, 2'b11);
        run_seg(1, 5, 4, 0, 1'b0, 2'b11);
        rst_n = 1'b0;
        #2;
        check_idle("async_rst");
        step();
        rst_n = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
